// File: rtl/t05_wb_sram_responder_pkg.sv
// ---------------------------------------------------------------------------
// t05_wb_pkg
// Shared definitions for the Wishbone SRAM responder: bus widths, the default
// base address of the SRAM window (also used by the manager's address map),
// the responder state enum and the address-decode helper.
// ---------------------------------------------------------------------------
package t05_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    localparam int WB_ADR_W  = 32;

    // Byte address of word 0 of the SRAM window.
    localparam logic [WB_ADR_W-1:0] WB_BASE_ADDR = 32'h3300_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // Rejects misaligned byte addresses and anything outside
    // [base, base + 4*depth). The end bound is formed in 33 bits so a window
    // that touches the top of the address space cannot wrap to a small value.
    function automatic logic wb_addr_err(input logic [WB_ADR_W-1:0] adr,
                                         input logic [WB_ADR_W-1:0] base,
                                         input int unsigned         depth_words);
        logic [WB_ADR_W:0] adr_ext;
        logic [WB_ADR_W:0] lo_bound;
        logic [WB_ADR_W:0] hi_bound;
        adr_ext  = {1'b0, adr};
        lo_bound = {1'b0, base};
        hi_bound = lo_bound + ((WB_ADR_W+1)'(depth_words) << 2);
        return (adr[1:0] != 2'b00) || (adr_ext < lo_bound) || (adr_ext >= hi_bound);
    endfunction

endpackage

// File: rtl/t05_wb_sram_responder_if.sv
// ---------------------------------------------------------------------------
// t05_wb_sram_responder_if
// Wishbone classic-cycle bus between the compression core's manager and the
// SRAM responder.
//   wbs_cyc_i / wbs_stb_i : cycle in progress / transfer strobe
//   wbs_we_i              : 1 = write, 0 = read
//   wbs_sel_i             : byte-lane enables
//   wbs_adr_i / wbs_dat_i : byte address / write data
//   wbs_ack_o / wbs_err_o : one-cycle completion / rejection pulse
//   wbs_dat_o             : read data
// Modports: master drives the request side, slave drives the response side.
// ---------------------------------------------------------------------------
interface t05_wb_sram_responder_if;
    import t05_wb_pkg::*;

    logic                 wbs_cyc_i;
    logic                 wbs_stb_i;
    logic                 wbs_we_i;
    logic [WB_SEL_W-1:0]  wbs_sel_i;
    logic [WB_ADR_W-1:0]  wbs_adr_i;
    logic [WB_DATA_W-1:0] wbs_dat_i;
    logic                 wbs_ack_o;
    logic                 wbs_err_o;
    logic [WB_DATA_W-1:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o
    );

endinterface

// File: rtl/t05_wb_sram_responder_mem.sv
// ---------------------------------------------------------------------------
// t05_wb_mem
// Single-port DEPTH x 32 word memory with per-byte write enables and a
// registered read port.
//   clk     : clock
//   wr_be   : byte-lane write enables (bit n writes bits [8n+7:8n])
//   rd_en   : capture mem[addr] into rd_data on this edge
//   addr    : word index
//   wr_data : write data
//   rd_data : registered read data, holds between reads
// There is deliberately no reset so the array maps onto SRAM.
// ---------------------------------------------------------------------------
module t05_wb_mem
    import t05_wb_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 clk,
    input  logic [WB_SEL_W-1:0]  wr_be,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WB_DATA_W-1:0] wr_data,
    output logic [WB_DATA_W-1:0] rd_data
);

    logic [WB_SEL_W-1:0][7:0] mem_array [DEPTH];

    // Lanes with a clear enable keep their previous contents; the read
    // register only moves when a read is requested.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < WB_SEL_W; lane++) begin
            if (wr_be[lane]) begin
                mem_array[addr][lane] <= wr_data[8*lane +: 8];
            end
        end
        if (rd_en) begin
            rd_data <= mem_array[addr];
        end
    end

endmodule

// File: rtl/t05_wb_sram_responder.sv
// ---------------------------------------------------------------------------
// t05_wb_sram_responder
// Wishbone classic-cycle subordinate in front of a byte-lane-writable word
// memory, with WAIT_STATES extra cycles before each ACK/ERR pulse.
//   hwclk  : system clock
//   reset  : asynchronous active-high reset (memory contents are kept)
//   wb     : Wishbone slave port (see t05_wb_sram_responder_if)
//   busy_o : high whenever the responder is not in IDLE
// ---------------------------------------------------------------------------
module t05_wb_sram_responder
    import t05_wb_pkg::*;
#(
    parameter int unsigned         DEPTH       = 256,
    parameter int unsigned         WAIT_STATES = 1,
    parameter logic [WB_ADR_W-1:0] BASE_ADDR   = WB_BASE_ADDR
) (
    input  logic                          hwclk,
    input  logic                          reset,
    t05_wb_sram_responder_if.slave        wb,
    output logic                          busy_o
);

    localparam int unsigned ADDR_W    = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    wb_state_e            state_q;
    logic [3:0]           wait_cnt;
    logic [WB_ADR_W-1:0]  lat_adr;
    logic                 lat_we;
    logic [WB_SEL_W-1:0]  lat_sel;
    logic [WB_DATA_W-1:0] lat_dat;
    logic                 lat_err;
    logic                 dat_from_mem;

    logic                 bus_err;
    logic [WB_ADR_W-1:0]  req_adr;
    logic                 req_we;
    logic [WB_SEL_W-1:0]  req_sel;
    logic [WB_DATA_W-1:0] req_dat;
    logic                 req_err;
    logic                 enter_resp;
    logic [WB_SEL_W-1:0]  mem_be;
    logic                 mem_rd;
    logic [ADDR_W-1:0]    mem_idx;
    logic [WB_DATA_W-1:0] mem_rdata;

    assign bus_err = wb_addr_err(wb.wbs_adr_i, BASE_ADDR, DEPTH);
    assign busy_o  = (state_q != IDLE);

    // The memory access happens on the edge that enters RESP. Coming straight
    // from IDLE (no wait states) the request is still only on the bus, so the
    // bus is used; from WAIT the latched copy is used. Reset suppresses the
    // access so a transfer interrupted by reset never reaches the array.
    always_comb begin
        req_adr    = lat_adr;
        req_we     = lat_we;
        req_sel    = lat_sel;
        req_dat    = lat_dat;
        req_err    = lat_err;
        enter_resp = 1'b0;
        if (state_q == IDLE) begin
            req_adr = wb.wbs_adr_i;
            req_we  = wb.wbs_we_i;
            req_sel = wb.wbs_sel_i;
            req_dat = wb.wbs_dat_i;
            req_err = bus_err;
        end
        case (state_q)
            IDLE:    enter_resp = wb.wbs_cyc_i && wb.wbs_stb_i && (WAIT_STATES == 0);
            WAIT:    enter_resp = wb.wbs_cyc_i && (wait_cnt == 4'd0);
            default: enter_resp = 1'b0;
        endcase
        if (reset) begin
            enter_resp = 1'b0;
        end
        mem_be  = (enter_resp && req_we && !req_err) ? req_sel : '0;
        mem_rd  = enter_resp && !req_we && !req_err;
        mem_idx = ADDR_W'((req_adr - BASE_ADDR) >> 2);
    end

    t05_wb_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (hwclk),
        .wr_be   (mem_be),
        .rd_en   (mem_rd),
        .addr    (mem_idx),
        .wr_data (req_dat),
        .rd_data (mem_rdata)
    );

    // The memory read register has no reset, so the visible read data is
    // gated by dat_from_mem: cleared by reset and by an erroring response,
    // set by a successful read. Between reads the memory register holds.
    assign wb.wbs_dat_o = dat_from_mem ? mem_rdata : '0;

    // Responder FSM: latch the request in IDLE, count wait states (aborting
    // if the manager drops cyc), then emit exactly one ACK or ERR pulse.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt     <= 4'd0;
            lat_adr      <= '0;
            lat_we       <= 1'b0;
            lat_sel      <= '0;
            lat_dat      <= '0;
            lat_err      <= 1'b0;
            dat_from_mem <= 1'b0;
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_err_o <= 1'b0;
        end else begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_err_o <= 1'b0;
            if (enter_resp) begin
                wb.wbs_ack_o <= !req_err;
                wb.wbs_err_o <= req_err;
                if (req_err) begin
                    dat_from_mem <= 1'b0;
                end else if (!req_we) begin
                    dat_from_mem <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
                        lat_adr <= wb.wbs_adr_i;
                        lat_we  <= wb.wbs_we_i;
                        lat_sel <= wb.wbs_sel_i;
                        lat_dat <= wb.wbs_dat_i;
                        lat_err <= bus_err;
                        if (WAIT_STATES == 0) begin
                            state_q <= RESP;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state_q  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!wb.wbs_cyc_i) begin
                        state_q <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t05_wb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_t05_wb_sram_responder
// Four responders (WAIT_STATES = 0, 1, 3, 4) share one set of manager
// signals; only the instance selected by 'active' sees cyc/stb, and its
// response is routed back. A per-instance word array models the memory.
// ---------------------------------------------------------------------------
module tb_t05_wb_sram_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h3300_0000;
    localparam int          NDUT  = 4;

    logic        hwclk = 1'b0;
    logic        reset = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic [1:0]  active = 2'd0;

    logic [NDUT-1:0] ack_v, err_v, busy_v;
    logic [31:0]     dat_v [NDUT];
    logic            ack, err, busy;
    logic [31:0]     dat_o;

    logic [31:0] model_mem [NDUT][DEPTH];
    logic [31:0] model_dat [NDUT];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 hwclk = ~hwclk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned WS_G = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
        t05_wb_sram_responder_if bus ();
        assign bus.wbs_cyc_i = cyc && (active == 2'(g));
        assign bus.wbs_stb_i = stb && (active == 2'(g));
        assign bus.wbs_we_i  = we;
        assign bus.wbs_sel_i = sel;
        assign bus.wbs_adr_i = adr;
        assign bus.wbs_dat_i = wdat;
        assign ack_v[g] = bus.wbs_ack_o;
        assign err_v[g] = bus.wbs_err_o;
        assign dat_v[g] = bus.wbs_dat_o;
        t05_wb_sram_responder #(
            .DEPTH       (DEPTH),
            .WAIT_STATES (WS_G),
            .BASE_ADDR   (BASE)
        ) dut (
            .hwclk  (hwclk),
            .reset  (reset),
            .wb     (bus),
            .busy_o (busy_v[g])
        );
    end

    assign ack   = ack_v[active];
    assign err   = err_v[active];
    assign busy  = busy_v[active];
    assign dat_o = dat_v[active];

    function automatic int ws_of(input int idx);
        case (idx)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    // Reference decode straight from the address-window rules.
    function automatic bit ref_err(input logic [31:0] a);
        longint unsigned av = a;
        longint unsigned lo = BASE;
        longint unsigned hi = lo + 4 * DEPTH;
        return ((av % 4) != 0) || (av < lo) || (av >= hi);
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        longint unsigned av = a;
        longint unsigned lo = BASE;
        return int'((av - lo) / 4);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h (dut %0d, t=%0t)",
                     tag, observed, expected, active, $time);
        end
    endtask

    // One transfer on the active responder, started right away (caller is
    // just past a rising edge); checked against the model, ending one edge
    // after the response pulse so the next transfer can start immediately.
    task automatic applyStimulus(input bit t_we, input logic [31:0] t_adr,
                                 input logic [3:0] t_sel, input logic [31:0] t_dat,
                                 output logic [31:0] got_dat);
        int          lat;
        bit          done;
        bit          e_err;
        logic [31:0] e_dat;
        logic [31:0] word;
        int          d = int'(active);

        e_err = ref_err(t_adr);
        if (e_err) begin
            e_dat = 32'h0;
        end else if (t_we) begin
            word = model_mem[d][ref_idx(t_adr)];
            for (int b = 0; b < 4; b++) begin
                if (t_sel[b]) word[8*b +: 8] = t_dat[8*b +: 8];
            end
            model_mem[d][ref_idx(t_adr)] = word;
            e_dat = model_dat[d];
        end else begin
            e_dat = model_mem[d][ref_idx(t_adr)];
        end
        model_dat[d] = e_dat;

        cyc = 1'b1; stb = 1'b1; we = t_we; sel = t_sel; adr = t_adr; wdat = t_dat;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge hwclk); #1;
            lat++;
            if (ack || err) done = 1'b1;
        end
        got_dat = dat_o;
        checkOutput("latency", 32'(lat), 32'(ws_of(d) + 1));
        checkOutput("ack", {31'b0, ack}, {31'b0, !e_err});
        checkOutput("err", {31'b0, err}, {31'b0, e_err});
        checkOutput("dat_o", dat_o, e_dat);
        cyc = 1'b0; stb = 1'b0;
        @(posedge hwclk); #1;
        checkOutput("pulse_end", {29'b0, ack, err, busy}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          k;

        $display("[TB] start");
        repeat (3) @(posedge hwclk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            active = 2'(d);
            #1;
            checkOutput("reset_state", {ack, err, busy, 29'b0}, 32'h0);
            checkOutput("reset_dat", dat_o, 32'h0);
            model_dat[d] = 32'h0;
        end
        @(posedge hwclk); #1;
        reset = 1'b0;

        // Fill every word of every instance so reads never see unknown data.
        for (int d = 0; d < NDUT; d++) begin
            active = 2'(d);
            for (int i = 0; i < DEPTH; i++) begin
                applyStimulus(1'b1, BASE + 32'(4*i), 4'hF, $urandom, rd);
            end
        end

        // Directed traffic on the single-wait-state instance.
        active = 2'd1;
        applyStimulus(1'b1, BASE + 32'd8, 4'hF, 32'hDEAD_BEEF, rd);
        applyStimulus(1'b0, BASE + 32'd8, 4'hF, 32'h0, rd);
        checkOutput("readback", rd, 32'hDEAD_BEEF);
        applyStimulus(1'b1, BASE + 32'd8, 4'b0101, 32'h1122_3344, rd);
        applyStimulus(1'b0, BASE + 32'd8, 4'b0000, 32'h0, rd);
        checkOutput("byte_lanes", rd, 32'hDE22_BE44);
        applyStimulus(1'b0, BASE + 32'(4*DEPTH), 4'hF, 32'h0, rd);
        checkOutput("oob_dat", rd, 32'h0);
        applyStimulus(1'b1, BASE + 32'd2, 4'hF, 32'h5555_AAAA, rd);
        applyStimulus(1'b0, BASE, 4'hF, 32'h0, rd);
        applyStimulus(1'b0, BASE + 32'(4*(DEPTH-1)), 4'hF, 32'h0, rd);
        applyStimulus(1'b1, BASE + 32'd12, 4'h0, 32'hFFFF_FFFF, rd);
        applyStimulus(1'b0, BASE + 32'd12, 4'hF, 32'h0, rd);

        // Back-to-back on the zero-wait instance: one transfer per 2 cycles.
        active = 2'd0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, BASE + 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i), rd);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, BASE + 32'(4*i), 4'hF, 32'h0, rd);
            checkOutput("b2b_readback", rd, 32'hA000_0000 + 32'(i));
        end

        // Abort: cyc dropped during WAIT on the four-wait instance.
        active = 2'd3;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'd20; wdat = 32'hCAFE_F00D;
        @(posedge hwclk); #1;
        checkOutput("abort_wait", {29'b0, ack, err, busy}, 32'h1);
        @(posedge hwclk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge hwclk); #1;
        checkOutput("abort_idle", {31'b0, busy}, 32'h0);
        k = 0;
        repeat (6) begin
            @(posedge hwclk); #1;
            if (ack || err) k++;
        end
        checkOutput("abort_no_resp", 32'(k), 32'h0);
        applyStimulus(1'b0, BASE + 32'd20, 4'hF, 32'h0, rd);

        // Reset in the middle of a three-wait-state write.
        active = 2'd2;
        applyStimulus(1'b0, BASE + 32'd24, 4'hF, 32'h0, rd);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'd24; wdat = ~rd;
        @(posedge hwclk); #1;
        reset = 1'b1;
        #1;
        checkOutput("reset_async", {ack, err, busy, 29'b0}, 32'h0);
        checkOutput("reset_async_dat", dat_o, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge hwclk); #1;
        reset = 1'b0;
        for (int d = 0; d < NDUT; d++) model_dat[d] = 32'h0;
        applyStimulus(1'b0, BASE + 32'd24, 4'hF, 32'h0, rd);
        checkOutput("reset_keeps_word", rd, model_mem[2][6]);

        // Randomised traffic on every instance.
        for (int d = 0; d < NDUT; d++) begin
            active = 2'(d);
            for (int n = 0; n < 30; n++) begin
                k = $urandom_range(0, 9);
                a = BASE + 32'(4 * $urandom_range(0, DEPTH-1));
                if (k == 0)      a = a + 32'($urandom_range(1, 3));
                else if (k == 1) a = BASE + 32'(4*DEPTH) + 32'(4 * $urandom_range(0, 7));
                else if (k == 2) a = BASE - 32'(4 * $urandom_range(1, 8));
                applyStimulus(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, rd);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
